// File: rtl/dcache_sa_controller.sv
// Set-associative write-back / write-allocate L1 data cache controller with tree pseudo-LRU.
// Latency: hits are answered combinationally in the request cycle; misses stall for 1 + refill (+ write-back) + 1 cycles.
// Backpressure: cpu_stall is raised in the miss cycle and held until the post-refill hit; memory is a level request held until mem_ack_i.
// Ports: clk_i/rst_i (sync, active-high); cpu_* load/store side; mem_* 256-bit line memory side.
// Optional: define DCACHE_PERF_CNT_EN to add saturating hit_cnt_o / miss_cnt_o / wb_cnt_o counters.
module dcache_sa_controller #(
  parameter int WAYS   = 2,
  parameter int SETS   = 16,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
  output logic [31:0]       wb_cnt_o
`endif
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int BOFF_W = $clog2(WORD_W / 8);
  localparam int WSEL_W = OFF_W - BOFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {IDLE, MISS, WB, ALLOC} state_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [LINE_W-1:0] data_q  [WAYS][SETS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [PLRU_W-1:0] plru_q  [SETS];

  logic [WAY_W-1:0]  vway_q;
  logic [IDX_W-1:0]  vidx_q;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] word_sel;
  logic              req;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [LINE_W-1:0] hit_line;
  logic [WAY_W-1:0]  vict_way;
  logic              vict_dirty;
  logic              hit_upd;
  logic              wr_hit;
  logic              refill;
  logic              latch_vict;
  logic              unused_bits;

  assign req_tag     = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx     = cpu_addr_i[OFF_W +: IDX_W];
  assign word_sel    = cpu_addr_i[BOFF_W +: WSEL_W];
  assign req         = cpu_MemRead_i | cpu_MemWrite_i;
  assign unused_bits = ^cpu_addr_i[BOFF_W-1:0];

  // Tree PLRU: bit 0 is the root (0 = victim on the low half); bits 1/2 pick within each pair.
  function automatic logic [WAY_W-1:0] plru_pick(input logic [PLRU_W-1:0] bits);
    logic [2:0] t;
    logic [1:0] r;
    t = '0;
    t[PLRU_W-1:0] = bits;
    r = 2'b00;
    if (WAYS == 2) r = {1'b0, t[0]};
    else if (WAYS == 4) r = t[0] ? {1'b1, t[2]} : {1'b0, t[1]};
    return r[WAY_W-1:0];
  endfunction

  // Mark a way most-recently used: every node on its path points away from it.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [2:0] t;
    logic [1:0] w;
    t = '0;
    t[PLRU_W-1:0] = bits;
    w = '0;
    w[WAY_W-1:0] = way;
    if (WAYS == 2) begin
      t[0] = ~w[0];
    end else if (WAYS == 4) begin
      t[0] = ~w[1];
      if (w[1]) t[2] = ~w[0];
      else      t[1] = ~w[0];
    end
    return t[PLRU_W-1:0];
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w[WAY_W-1:0]] && (tag_q[w[WAY_W-1:0]][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = w[WAY_W-1:0];
      end
    end
  end

  assign hit_line = data_q[hit_way][req_idx];

  // Walk downwards so the lowest-numbered invalid way is the one left standing.
  always_comb begin
    vict_way = plru_pick(plru_q[req_idx]);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w[WAY_W-1:0]]) vict_way = w[WAY_W-1:0];
    end
  end

  assign vict_dirty = valid_q[req_idx][vict_way] & dirty_q[req_idx][vict_way];

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Memory-side outputs depend on the state register only, so mem_enable_o falls
  // on the edge that consumes the final ack.
  always_comb begin
    state_d      = state_q;
    cpu_stall_o  = 1'b0;
    cpu_data_o   = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    hit_upd      = 1'b0;
    wr_hit       = 1'b0;
    refill       = 1'b0;
    latch_vict   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            cpu_data_o = hit_line[word_sel*WORD_W +: WORD_W];
            hit_upd    = 1'b1;
            wr_hit     = cpu_MemWrite_i;
          end else begin
            cpu_stall_o = 1'b1;
            state_d     = MISS;
          end
        end
      end
      MISS: begin
        cpu_stall_o = 1'b1;
        latch_vict  = 1'b1;
        state_d     = vict_dirty ? WB : ALLOC;
      end
      WB: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[vway_q][vidx_q], vidx_q, {OFF_W{1'b0}}};
        mem_data_o   = data_q[vway_q][vidx_q];
        if (mem_ack_i) state_d = ALLOC;
      end
      ALLOC: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, vidx_q, {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          refill  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '{default: '0};
      dirty_q <= '{default: '0};
      plru_q  <= '{default: '0};
      vway_q  <= '0;
      vidx_q  <= '0;
    end else begin
      if (latch_vict) begin
        vway_q <= vict_way;
        vidx_q <= req_idx;
      end
      if (hit_upd) plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
      if (wr_hit)  dirty_q[req_idx][hit_way] <= 1'b1;
      if (refill) begin
        valid_q[vidx_q][vway_q] <= 1'b1;
        dirty_q[vidx_q][vway_q] <= 1'b0;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (refill) begin
        tag_q[vway_q][vidx_q]  <= req_tag;
        data_q[vway_q][vidx_q] <= mem_data_i;
      end
      if (wr_hit) data_q[hit_way][req_idx][word_sel*WORD_W +: WORD_W] <= cpu_data_i;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // The hit that completes a refill is part of the miss, not a hit of its own.
  logic refilled_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      refilled_q <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      refilled_q <= refill;
      if ((state_q == IDLE) && req && hit && !refilled_q && (hit_cnt_o != '1))
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if ((state_q == IDLE) && (state_d == MISS) && (miss_cnt_o != '1))
        miss_cnt_o <= miss_cnt_o + 32'd1;
      if ((state_q == WB) && mem_ack_i && (wb_cnt_o != '1))
        wb_cnt_o <= wb_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_sa_controller.sv
// Bench for dcache_sa_controller (WAYS=2, SETS=16): table of CPU operations with a
// scoreboard of expected memory transactions checked by a behavioural line memory.
// Optional counters are checked when DCACHE_PERF_CNT_EN is defined.
module tb_dcache_sa_controller;
  localparam int LAT = 10;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic         cpu_MemRead_i = 1'b0;
  logic         cpu_MemWrite_i = 1'b0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o, wb_cnt_o;
`endif

  dcache_sa_controller #(.WAYS(2), .SETS(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o)
`ifdef DCACHE_PERF_CNT_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .wb_cnt_o(wb_cnt_o)
`endif
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    bit          rst;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] data;
    int          stall;
    bit          wb;
    logic [31:0] wb_addr;
    logic [31:0] wb_w0;
    bit          alloc;
    bit          perf;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] w0;
  } mtx_t;

  mtx_t         exp_q[$];
  logic [255:0] mem_q [logic [31:0]];
  int           n_chk = 0;
  int           n_fail = 0;
  bit           hold = 1'b0;
  bit           inject_ack = 1'b0;
  vec_t         vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pat(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hC0DE_0000 | (a + 32'(4 * k));
    return l;
  endfunction

  // Line memory: acks on the LAT-th cycle of a held request and checks each
  // transaction against the scoreboard.
  initial begin
    int   cnt;
    mtx_t e;
    logic [255:0] l;
    cnt = 0;
    l = pat(32'h40);
    l[31:0] = 32'hDEAD_BEEF;
    mem_q[32'h40] = l;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (rst_i) begin
        cnt = 0;
      end else if (inject_ack) begin
        mem_ack_i = 1'b1;
      end else if (mem_enable_o && !hold) begin
        cnt++;
        if (cnt == LAT) begin
          cnt = 0;
          mem_ack_i = 1'b1;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL mem_txn: unexpected request to %h, none required", mem_addr_o);
          end else begin
            e = exp_q.pop_front();
            check("mem_write", {31'b0, mem_write_o}, {31'b0, e.wr});
            check("mem_addr", mem_addr_o, e.addr);
            if (e.wr) check("wb_word0", mem_data_o[31:0], e.w0);
          end
          if (mem_write_o) mem_q[mem_addr_o] = mem_data_o;
          else mem_data_i = mem_q.exists(mem_addr_o) ? mem_q[mem_addr_o] : pat(mem_addr_o);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    cpu_MemRead_i = 1'b0;
    cpu_MemWrite_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    int   stalls;
    bit   done;
    logic [31:0] got;
    mtx_t m;
    if (v.rst) do_reset();
    @(posedge clk_i); #1;
    cpu_MemRead_i  = v.rd;
    cpu_MemWrite_i = v.wr;
    cpu_addr_i     = v.addr;
    cpu_data_i     = v.wdata;
    if (v.wb) begin
      m = '{1'b1, v.wb_addr, v.wb_w0};
      exp_q.push_back(m);
    end
    if (v.alloc) begin
      m = '{1'b0, v.addr & ~32'h1F, 32'h0};
      exp_q.push_back(m);
    end
    stalls = 0;
    done = 1'b0;
    got = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk_i);
      if (cpu_stall_o) stalls++;
      else begin
        done = 1'b1;
        got = cpu_data_o;
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL op_timeout: addr %h still stalled, required completion", v.addr);
    end
    check("stall_cycles", 32'(stalls), 32'(v.stall));
    if (v.chk) check("cpu_data", got, v.data);
    check("mem_txns_left", 32'(exp_q.size()), 32'd0);
    if (v.perf) begin
`ifdef DCACHE_PERF_CNT_EN
      check("hit_cnt", hit_cnt_o, 32'd1);
      check("miss_cnt", miss_cnt_o, 32'd3);
      check("wb_cnt", wb_cnt_o, 32'd1);
`endif
    end
  endtask

  initial begin
    vec_t h;
    bit   seen;
    //           rst   rd    wr    addr     wdata          chk   data          st  wb    wb_addr wb_w0          alloc perf
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h040, 32'h0,         1'b1, 32'hDEADBEEF, 12, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h040, 32'h12345678,  1'b1, 32'hDEADBEEF,  0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h240, 32'h0,         1'b1, 32'hC0DE0240, 12, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h440, 32'h0,         1'b1, 32'hC0DE0440, 22, 1'b1, 32'h40, 32'h12345678,  1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h040, 32'h0,         1'b1, 32'h12345678, 12, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h040, 32'h0,         1'b1, 32'h12345678, 12, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h240, 32'h0,         1'b1, 32'hC0DE0240, 12, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h040, 32'h0,         1'b1, 32'h12345678,  0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h440, 32'h0,         1'b1, 32'hC0DE0440, 12, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h040, 32'h0,         1'b1, 32'h12345678,  0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h240, 32'h0,         1'b1, 32'hC0DE0240, 12, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h084, 32'hA5A5A5A5,  1'b1, 32'hC0DE0084, 12, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h084, 32'h0,         1'b1, 32'hA5A5A5A5,  0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h080, 32'h0,         1'b1, 32'hC0DE0080,  0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h088, 32'h0BADF00D,  1'b1, 32'hC0DE0088,  0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h088, 32'h0,         1'b1, 32'h0BADF00D,  0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_stall", {31'b0, cpu_stall_o}, 32'd0);
    check("rst_mem_enable", {31'b0, mem_enable_o}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_data", mem_data_o[31:0], 32'd0);
    check("rst_cpu_data", cpu_data_o, 32'd0);

    for (int i = 0; i < 16; i++) run_op(vecs[i]);

    // Reset during a write-back, then a stray ack.
    h = '{1'b1, 1'b1, 1'b0, 32'h040, 32'h0, 1'b1, 32'h12345678, 12, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    run_op(h);
    h = '{1'b0, 1'b0, 1'b1, 32'h040, 32'hCAFEF00D, 1'b1, 32'h12345678, 0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    run_op(h);
    h = '{1'b0, 1'b1, 1'b0, 32'h240, 32'h0, 1'b1, 32'hC0DE0240, 12, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    run_op(h);
    hold = 1'b1;
    @(posedge clk_i); #1;
    cpu_MemRead_i = 1'b1;
    cpu_MemWrite_i = 1'b0;
    cpu_addr_i = 32'h440;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk_i);
      if (mem_enable_o) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL wb_start: no memory request seen, required write-back");
    end
    check("abort_wb_write", {31'b0, mem_write_o}, 32'd1);
    check("abort_wb_addr", mem_addr_o, 32'h40);
    check("abort_wb_word0", mem_data_o[31:0], 32'hCAFEF00D);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    cpu_MemRead_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("abort_mem_enable", {31'b0, mem_enable_o}, 32'd0);
    check("abort_stall", {31'b0, cpu_stall_o}, 32'd0);
    check("abort_mem_addr", mem_addr_o, 32'd0);
    hold = 1'b0;
    @(posedge clk_i); #1;
    inject_ack = 1'b1;
    @(posedge clk_i); #1;
    inject_ack = 1'b0;
    @(negedge clk_i);
    check("stale_ack_mem_enable", {31'b0, mem_enable_o}, 32'd0);
    check("stale_ack_stall", {31'b0, cpu_stall_o}, 32'd0);
    h = '{1'b0, 1'b1, 1'b0, 32'h040, 32'h0, 1'b1, 32'h12345678, 12, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    run_op(h);

    @(posedge clk_i); #1;
    cpu_MemRead_i = 1'b0;
    cpu_MemWrite_i = 1'b0;
    repeat (3) @(posedge clk_i);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_sa_controller.md
Name: dcache_sa_controller

Overview:
Parametrised set-associative, write-back, write-allocate L1 data cache controller. It replaces the direct-mapped dcache between the EX/MEM pipeline register and the external 256-bit line memory. Tag, valid, dirty and data arrays are internal register arrays. Victim selection uses tree pseudo-LRU. The block stalls the whole pipeline through cpu_stall_o while a miss is serviced.

Parameters:
WAYS, 2, associativity; legal values 1, 2, 4
SETS, 16, sets per way; power of two, 2..256
LINE_W, 256, line width in bits; fixed by the memory interface
ADDR_W, 32, byte address width
WORD_W, 32, CPU data width
Derived values: OFF_W = log2(LINE_W/8) = 5; IDX_W = log2(SETS); TAG_W = ADDR_W - IDX_W - OFF_W.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high (sampled on rising clk_i)
cpu_addr_i  in  ADDR_W  byte address; word-aligned
cpu_data_i  in  WORD_W  store data
cpu_MemRead_i  in  1  load request
cpu_MemWrite_i  in  1  store request
cpu_data_o  out  WORD_W  load data
cpu_stall_o  out  1  pipeline stall
mem_data_i  in  LINE_W  refill line
mem_ack_i  in  1  memory completion pulse
mem_data_o  out  LINE_W  write-back line
mem_addr_o  out  ADDR_W  line-aligned address; low OFF_W bits = 0
mem_enable_o  out  1  memory request
mem_write_o  out  1  1 = write-back, 0 = refill

Behaviour:
- Reset: all valid, dirty and PLRU bits = 0; state = IDLE; cpu_stall_o = 0; mem_enable_o = 0; mem_write_o = 0; mem_addr_o = 0; mem_data_o = 0; cpu_data_o = 0. Data and tag arrays are not cleared.
- Request = cpu_MemRead_i | cpu_MemWrite_i. If both are high, the access is a store; cpu_data_o is still driven from the hit word.
- Lookup is combinational in IDLE: a hit is a tag match on a valid way at index cpu_addr_i[OFF_W+IDX_W-1:OFF_W].
- Read hit: cpu_data_o = selected word at cpu_addr_i[OFF_W-1:2], same cycle. cpu_stall_o = 0.
- Write hit: the word is written on the next edge and the line's dirty bit is set. cpu_stall_o = 0.
- Any hit updates the set's PLRU toward the hit way on the clock edge.
- No request: cpu_stall_o = 0; arrays and PLRU are unchanged.
- Miss: cpu_stall_o = 1 combinationally in the same cycle and stays 1 until the hit cycle after refill.
- Victim choice: the first invalid way, lowest index first. Otherwise the PLRU way. WAYS = 1 always selects way 0.
- Hold requirement: cpu_addr_i, cpu_data_i and the request signals are held by the stalled pipeline for the whole miss.
- State machine:
  - IDLE -> MISS on a request that misses.
  - MISS (1 cycle, latches victim way and index): if victim is valid and dirty -> WB, else -> ALLOC.
  - WB: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 0}, mem_data_o = victim line. On the cycle mem_ack_i = 1 -> ALLOC.
  - ALLOC: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {request tag, index, 0}. On mem_ack_i = 1, capture mem_data_i into the victim way; set valid = 1, dirty = 0; write the tag -> IDLE.
  - Back in IDLE the request now hits. A store merges and sets dirty in that cycle.
- mem_enable_o drops the cycle after ack, i.e. it is registered.
- mem_ack_i outside WB/ALLOC is ignored.
- Reset mid-miss: next edge returns to IDLE with all outputs at reset values. A later stale ack is ignored.
- Minimum miss penalty: clean = 1 + mem latency + 1 cycles; dirty adds one further memory latency.

Optional Feature:
DCACHE_PERF_CNT_EN
- Defined: adds outputs hit_cnt_o, miss_cnt_o and wb_cnt_o, each 32 bits.
  - hit_cnt_o increments on each IDLE hit cycle where cpu_stall_o = 0, excluding the post-refill hit.
  - miss_cnt_o increments on each IDLE -> MISS transition.
  - wb_cnt_o increments on each WB ack.
  - Counters saturate at 0xFFFFFFFF and clear on rst_i.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Cold read miss: after reset, load 0x0000_0040, memory line word 0 = 0xDEAD_BEEF, ack after 10 cycles -> one ALLOC with mem_addr_o = 0x40 and mem_write_o = 0; cpu_stall_o high for 12 cycles; then cpu_data_o = 0xDEAD_BEEF.
- Write hit then eviction, WAYS = 2, SETS = 16:
  - Store 0x1234_5678 to 0x40 (hit), then load 0x240 and 0x440, all index 2.
  - Load 0x440 evicts the PLRU way holding 0x40 -> WB with mem_addr_o = 0x40, mem_data_o[31:0] = 0x1234_5678, then ALLOC of 0x440.
- PLRU: fill both ways of set 2 with 0x40 and 0x240, read 0x40, then miss on 0x440 -> the 0x240 line is evicted (clean, no WB).
- Store miss: store 0xA5A5_A5A5 to 0x84 on a cold cache -> ALLOC 0x80, then merge into word 1; a subsequent load 0x84 hits with no stall and returns 0xA5A5_A5A5.
- Reset mid-WB: assert rst_i during WB before ack -> next cycle mem_enable_o = 0 and cpu_stall_o = 0; a later ack has no effect; load 0x40 misses.
- DCACHE_PERF_CNT_EN: after the eviction scenario, hit_cnt_o = 1, miss_cnt_o = 3, wb_cnt_o = 1.
